// File: rtl/oled12832_driver.sv
// ---------------------------------------------------------------------------
// oled12832_driver
//
// Stand-alone driver for a 128x32 SSD1306-class OLED over a 4-wire,
// write-only SPI link. After reset it pulses the panel reset line, sends a
// fixed init command sequence, and then refreshes the full 512-byte frame
// forever in horizontal addressing mode. The pixel pattern comes from the
// 4-bit switch input, which is latched once at the start of every frame.
//
// Optional feature macro: OLED_INVERT_EN
//   defined   -> the 24th init byte is A7 (inverse display)
//   undefined -> the 24th init byte is A6 (normal display)
//
// Parameters:
//   CLK_DIV       SCLK half-period in clk cycles (>= 1)
//   RST_LOW_CYC   clk cycles oled_rst is held low after rst_n release
//   RST_WAIT_CYC  clk cycles between oled_rst rising and the first init byte
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   sw[3:0]   in   pattern select, sampled once per frame
//   oled_csn  out  SPI chip select, active low
//   oled_rst  out  panel reset, active low
//   oled_dcn  out  0 = command byte, 1 = display data byte
//   oled_clk  out  SPI clock, mode 0 (idle low)
//   oled_dat  out  SPI data, MSB first
// ---------------------------------------------------------------------------
module oled12832_driver #(
  parameter int CLK_DIV      = 2,
  parameter int RST_LOW_CYC  = 200,
  parameter int RST_WAIT_CYC = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  output logic       oled_csn,
  output logic       oled_rst,
  output logic       oled_dcn,
  output logic       oled_clk,
  output logic       oled_dat
);

  localparam int CNT_MAX = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = $clog2(CLK_DIV + 1);

  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RST_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_RST_LOW,
    S_RST_WAIT,
    S_INIT,
    S_ADDR,
    S_DATA
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       phase;
  logic [8:0]       idx;
  logic [8:0]       idx_nxt;
  logic [7:0]       tx_byte;
  logic [3:0]       pattern;

  assign idx_nxt = idx + 9'd1;

  function automatic logic [7:0] init_byte(input logic [4:0] n);
    logic [7:0] b;
    case (n)
      5'd0:  b = 8'hAE;
      5'd1:  b = 8'hD5;
      5'd2:  b = 8'h80;
      5'd3:  b = 8'hA8;
      5'd4:  b = 8'h1F;
      5'd5:  b = 8'hD3;
      5'd6:  b = 8'h00;
      5'd7:  b = 8'h40;
      5'd8:  b = 8'h8D;
      5'd9:  b = 8'h14;
      5'd10: b = 8'h20;
      5'd11: b = 8'h00;
      5'd12: b = 8'hA1;
      5'd13: b = 8'hC8;
      5'd14: b = 8'hDA;
      5'd15: b = 8'h02;
      5'd16: b = 8'h81;
      5'd17: b = 8'h8F;
      5'd18: b = 8'hD9;
      5'd19: b = 8'hF1;
      5'd20: b = 8'hDB;
      5'd21: b = 8'h40;
      5'd22: b = 8'hA4;
`ifdef OLED_INVERT_EN
      5'd23: b = 8'hA7;
`else
      5'd23: b = 8'hA6;
`endif
      5'd24: b = 8'hAF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Column window 0..127, page window 0..3
  function automatic logic [7:0] addr_byte(input logic [2:0] n);
    logic [7:0] b;
    case (n)
      3'd0:    b = 8'h21;
      3'd1:    b = 8'h00;
      3'd2:    b = 8'h7F;
      3'd3:    b = 8'h22;
      3'd4:    b = 8'h00;
      3'd5:    b = 8'h03;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Byte i covers column i[6:0] of page i[8:7]; bit n is row 8*page+n.
  function automatic logic [7:0] pixel_byte(input logic [3:0] pat, input logic [8:0] i);
    logic [6:0] c;
    logic [1:0] p;
    logic [7:0] b;
    c = i[6:0];
    p = i[8:7];
    case (pat)
      4'd0: b = 8'h00;
      4'd1: b = 8'hFF;
      4'd2: b = c[0] ? 8'h55 : 8'hAA;
      4'd3: b = c[3] ? 8'hFF : 8'h00;
      4'd4: b = 8'h01;
      4'd5: b = {8{p[0]}};
      4'd6: begin
        if (c == 7'd0 || c == 7'd127) b = 8'hFF;
        else b = ((p == 2'd0) ? 8'h01 : 8'h00) | ((p == 2'd3) ? 8'h80 : 8'h00);
      end
      default: b = {pat, pat};
    endcase
    return b;
  endfunction

  // A byte is 18 phases of CLK_DIV cycles each:
  //   phase 0       csn high, dcn already valid for the byte
  //   phases 1..16  csn low, 8 bits as (clk low, clk high) pairs
  //   phase 17      csn low, clk low, hold before csn rises
  // All outputs are registered and updated on phase boundaries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_RST_LOW;
      cnt      <= '0;
      div_cnt  <= '0;
      phase    <= '0;
      idx      <= '0;
      tx_byte  <= '0;
      pattern  <= '0;
      oled_csn <= 1'b1;
      oled_rst <= 1'b0;
      oled_dcn <= 1'b0;
      oled_clk <= 1'b0;
      oled_dat <= 1'b0;
    end else begin
      case (state)
        S_RST_LOW: begin
          if (cnt == LOW_LAST) begin
            cnt      <= '0;
            oled_rst <= 1'b1;
            state    <= S_RST_WAIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_RST_WAIT: begin
          if (cnt == WAIT_LAST) begin
            cnt      <= '0;
            state    <= S_INIT;
            idx      <= '0;
            phase    <= '0;
            div_cnt  <= '0;
            tx_byte  <= init_byte(5'd0);
            oled_dcn <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (phase == 5'd17) begin
              // Byte done: raise csn and stage the next byte and its D/C level.
              phase    <= '0;
              oled_csn <= 1'b1;
              oled_clk <= 1'b0;
              case (state)
                S_INIT: begin
                  if (idx == 9'd24) begin
                    state    <= S_ADDR;
                    idx      <= '0;
                    pattern  <= sw;
                    tx_byte  <= addr_byte(3'd0);
                  end else begin
                    idx      <= idx_nxt;
                    tx_byte  <= init_byte(idx_nxt[4:0]);
                  end
                  oled_dcn <= 1'b0;
                end
                S_ADDR: begin
                  if (idx == 9'd5) begin
                    state    <= S_DATA;
                    idx      <= '0;
                    tx_byte  <= pixel_byte(pattern, 9'd0);
                    oled_dcn <= 1'b1;
                  end else begin
                    idx      <= idx_nxt;
                    tx_byte  <= addr_byte(idx_nxt[2:0]);
                    oled_dcn <= 1'b0;
                  end
                end
                S_DATA: begin
                  if (idx == 9'd511) begin
                    state    <= S_ADDR;
                    idx      <= '0;
                    pattern  <= sw;
                    tx_byte  <= addr_byte(3'd0);
                    oled_dcn <= 1'b0;
                  end else begin
                    idx      <= idx_nxt;
                    tx_byte  <= pixel_byte(pattern, idx_nxt);
                    oled_dcn <= 1'b1;
                  end
                end
                default: state <= S_RST_LOW;
              endcase
            end else begin
              phase <= phase + 5'd1;
              if (phase == 5'd0) begin
                oled_csn <= 1'b0;
                oled_dat <= tx_byte[7];
              end else if (phase == 5'd16) begin
                oled_clk <= 1'b0;
              end else if (phase[0]) begin
                oled_clk <= 1'b1;
              end else begin
                // Falling SCLK edge: present the next bit from the shifter.
                oled_clk <= 1'b0;
                oled_dat <= tx_byte[6];
                tx_byte  <= {tx_byte[6:0], 1'b0};
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled12832_driver.sv
// ---------------------------------------------------------------------------
// tb_oled12832_driver
//
// Self-checking bench for oled12832_driver with default parameters. A
// monitor decodes SPI bytes (sampled on SCLK rising while CS# is low) into a
// queue of {dcn, byte}; the main sequence compares them against hand-written
// constants and a table of {sw, byte index, expected byte} records.
// ---------------------------------------------------------------------------
module tb_oled12832_driver;

  localparam int H = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       oled_csn;
  logic       oled_rst;
  logic       oled_dcn;
  logic       oled_clk;
  logic       oled_dat;

  always #5 clk = ~clk;

  oled12832_driver dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .oled_csn (oled_csn),
    .oled_rst (oled_rst),
    .oled_dcn (oled_dcn),
    .oled_clk (oled_clk),
    .oled_dat (oled_dat)
  );

  typedef struct {
    logic [3:0] sw_val;
    int         index;
    logic [7:0] expect_byte;
  } vec_t;

  vec_t       vecs [12];
  logic [7:0] init_exp [25];

  int compared   = 0;
  int mismatched = 0;
  bit stalled    = 1'b0;

  // Monitor state
  logic [8:0] cap_q [$];
  logic [7:0] sh = '0;
  int         bit_cnt = 0;
  int         win_len = 0;
  int         windows = 0;
  int         bad_win = 0;
  int         viol    = 0;
  bit         in_win  = 1'b0;
  logic       prev_clk = 1'b0;
  logic       prev_dat = 1'b0;
  logic       prev_dcn = 1'b0;

  // Decode bytes and watch framing rules on every falling clk edge.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      bit_cnt = 0;
      win_len = 0;
      in_win  = 1'b0;
    end else begin
      if (oled_csn === 1'b0) begin
        win_len++;
        in_win = 1'b1;
        if (oled_dcn !== prev_dcn) viol++;
        if (oled_clk === 1'b1 && prev_clk === 1'b0) begin
          sh = {sh[6:0], oled_dat};
          bit_cnt++;
          if (bit_cnt == 8) begin
            cap_q.push_back({oled_dcn, sh});
            bit_cnt = 0;
          end
        end
      end else begin
        if (in_win) begin
          windows++;
          if (win_len != 17 * H) bad_win++;
        end
        in_win  = 1'b0;
        win_len = 0;
        bit_cnt = 0;
        if (oled_clk !== 1'b0) viol++;
      end
      if (oled_clk === 1'b1 && oled_dat !== prev_dat) viol++;
    end
    prev_clk = oled_clk;
    prev_dat = oled_dat;
    prev_dcn = oled_dcn;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic rst_v, input logic [3:0] sw_v);
    @(negedge clk);
    rst_n = rst_v;
    sw    = sw_v;
  endtask

  task automatic get_byte(output logic [8:0] b);
    int waited;
    waited = 0;
    b = '0;
    if (!stalled) begin
      while (cap_q.size() == 0 && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (cap_q.size() == 0) begin
        compared++;
        mismatched++;
        stalled = 1'b1;
        $display("[TB] FAIL byte_timeout: no byte after %0d cycles, expected one", waited);
      end else begin
        b = cap_q.pop_front();
      end
    end
  endtask

  // One frame: 6 address commands, then n_data data bytes. full_val >= 0
  // means every data byte must equal it; table entries for fsw are checked too.
  task automatic check_frame(input string tag, input logic [3:0] fsw, input int full_val,
                             input int n_data, input int sw_at, input logic [3:0] sw_new);
    logic [8:0] b;
    logic [7:0] addr_exp [6];
    addr_exp = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h03};
    for (int k = 0; k < 6; k++) begin
      get_byte(b);
      check_output($sformatf("%s_addr%0d", tag, k), {23'd0, b}, {23'd0, 1'b0, addr_exp[k]});
    end
    for (int i = 0; i < n_data; i++) begin
      get_byte(b);
      if (full_val >= 0)
        check_output($sformatf("%s_data%0d", tag, i), {23'd0, b}, {23'd0, 1'b1, 8'(full_val)});
      for (int v = 0; v < 12; v++) begin
        if (vecs[v].sw_val == fsw && vecs[v].index == i)
          check_output($sformatf("%s_vec%0d_i%0d", tag, v, i), {23'd0, b},
                       {23'd0, 1'b1, vecs[v].expect_byte});
      end
      if (i == sw_at) sw = sw_new;
    end
  endtask

  initial begin
    int         low_cnt;
    int         gap;
    int         w;
    logic [8:0] b;

    vecs[0]  = '{4'd6, 0,   8'hFF};
    vecs[1]  = '{4'd6, 1,   8'h01};
    vecs[2]  = '{4'd6, 127, 8'hFF};
    vecs[3]  = '{4'd6, 128, 8'hFF};
    vecs[4]  = '{4'd6, 129, 8'h00};
    vecs[5]  = '{4'd6, 300, 8'h00};
    vecs[6]  = '{4'd6, 385, 8'h80};
    vecs[7]  = '{4'd6, 511, 8'hFF};
    vecs[8]  = '{4'd2, 0,   8'hAA};
    vecs[9]  = '{4'd2, 1,   8'h55};
    vecs[10] = '{4'd2, 2,   8'hAA};
    vecs[11] = '{4'd2, 3,   8'h55};

    init_exp = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h1F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h02, 8'h81, 8'h8F,
                 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
`ifdef OLED_INVERT_EN
    init_exp[23] = 8'hA7;
`endif

    rst_n = 1'b0;
    sw    = 4'd1;

    // Reset held: {csn, rst, dcn, clk, dat} = 1,0,0,0,0
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_output($sformatf("reset_hold%0d", k),
                   {27'd0, oled_csn, oled_rst, oled_dcn, oled_clk, oled_dat}, 32'h10);
    end

    // Release and measure the panel reset pulse
    rst_n   = 1'b1;
    low_cnt = 0;
    do begin
      low_cnt++;
      @(negedge clk);
    end while (oled_rst === 1'b0 && low_cnt < 1000);
    check_output("rst_low_cycles", low_cnt, 200);

    gap = 0;
    while (oled_csn !== 1'b0 && gap < 1000) begin
      @(negedge clk);
      gap++;
    end
    check_output("first_csn_gap_in_range", {31'd0, (gap >= 200 && gap <= 200 + 2 * H)}, 1);
    check_output("rst_high_after_wait", {31'd0, oled_rst}, 1);

    for (int k = 0; k < 25; k++) begin
      get_byte(b);
      check_output($sformatf("init%0d", k), {23'd0, b}, {23'd0, 1'b0, init_exp[k]});
    end

    check_frame("frameA_sw1", 4'd1, 'hFF, 512, 10,  4'd0);
    check_frame("frameB_sw0", 4'd0, 'h00, 512, 100, 4'd9);
    check_frame("frameC_sw9", 4'd9, 'h99, 512, 10,  4'd6);
    check_frame("frameD_sw6", 4'd6, -1,   512, 450, 4'd2);
    check_frame("frameE_sw2", 4'd2, -1,   4,   -1,  4'd2);

    // Reset in the middle of a byte must abort on the next edge
    w = 0;
    while (!(oled_csn === 1'b0 && oled_clk === 1'b1) && w < 200) begin
      @(negedge clk);
      w++;
    end
    check_output("midbyte_found", {31'd0, (oled_csn === 1'b0 && oled_clk === 1'b1)}, 1);
    apply_stimulus(1'b0, 4'd2);
    @(negedge clk);
    check_output("midbyte_reset",
                 {27'd0, oled_csn, oled_rst, oled_dcn, oled_clk, oled_dat}, 32'h10);
    @(negedge clk);
    check_output("midbyte_reset_hold",
                 {27'd0, oled_csn, oled_rst, oled_dcn, oled_clk, oled_dat}, 32'h10);

    check_output("protocol_violations", viol, 0);
    check_output("csn_window_len_bad", bad_win, 0);
    check_output("csn_windows_seen", {31'd0, (windows >= 1000)}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
